// File: rtl/ddr4_req_queue.sv
// CPU-side request queue for the DDR4 controller port: buffers requests, issues them one at a
// time with crd/cwr/ca/cwdat held until cdone, and returns responses on a valid/ready channel.
module ddr4_req_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 31,
    parameter int DW    = 4,
    parameter int TMO   = 1024
) (
    input  logic                     clkin,
    input  logic                     crst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_we,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     crd,
    output logic                     cwr,
    output logic [AW-1:0]            ca,
    output logic [DW-1:0]            cwdat,
    input  logic [DW-1:0]            crdat,
    input  logic                     cdone,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_spur,
    output logic                     err_tmo
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            mem_we_q    [DEPTH];
    logic [AW-1:0]   mem_addr_q  [DEPTH];
    logic [DW-1:0]   mem_wdata_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cnt_q;
    logic            crd_q, cwr_q, rsp_valid_q, rsp_we_q;
    logic [AW-1:0]   ca_q;
    logic [DW-1:0]   cwdat_q, rsp_rdata_q;
    logic            err_spur_q, err_tmo_q;
    logic            push_s, pop_s, ready_s;

    assign ready_s   = (level_q < LW'(DEPTH));
    assign push_s    = req_valid & ready_s;
    assign pop_s     = (state_q == S_IDLE) && (level_q != {LW{1'b0}});

    assign req_ready = ready_s;
    assign level     = level_q;
    assign crd       = crd_q;
    assign cwr       = cwr_q;
    assign ca        = ca_q;
    assign cwdat     = cwdat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_spur  = err_spur_q;
    assign err_tmo   = err_tmo_q;

    // Next pointer and occupancy values; a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clkin or posedge crst) begin
        if (crst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Request storage; cleared on reset so discarded requests leave no trace.
    always_ff @(posedge clkin or posedge crst) begin
        if (crst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_we_q[i]    <= 1'b0;
                mem_addr_q[i]  <= {AW{1'b0}};
                mem_wdata_q[i] <= {DW{1'b0}};
            end
        end else if (push_s) begin
            mem_we_q[wr_ptr_q]    <= req_we;
            mem_addr_q[wr_ptr_q]  <= req_addr;
            mem_wdata_q[wr_ptr_q] <= req_wdata;
        end
    end

    // Arbitration FSM with registered controller and response outputs.
    always_ff @(posedge clkin or posedge crst) begin
        if (crst) begin
            state_q     <= S_IDLE;
            crd_q       <= 1'b0;
            cwr_q       <= 1'b0;
            ca_q        <= {AW{1'b0}};
            cwdat_q     <= {DW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= {DW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            err_spur_q  <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cdone) begin
                        err_spur_q <= 1'b1;
                    end
                    if (pop_s) begin
                        ca_q     <= mem_addr_q[rd_ptr_q];
                        cwdat_q  <= mem_wdata_q[rd_ptr_q];
                        rsp_we_q <= mem_we_q[rd_ptr_q];
                        crd_q    <= ~mem_we_q[rd_ptr_q];
                        cwr_q    <= mem_we_q[rd_ptr_q];
                        cnt_q    <= {CW{1'b0}};
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cdone) begin
                        crd_q       <= 1'b0;
                        cwr_q       <= 1'b0;
                        rsp_rdata_q <= rsp_we_q ? {DW{1'b0}} : crdat;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= {CW{1'b0}};
                        state_q     <= S_RESP;
                    end else begin
                        // Saturate at TMO; the access stays outstanding after the flag sets.
                        if (cnt_q != CW'(TMO)) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                        if (cnt_q == CW'(TMO - 1)) begin
                            err_tmo_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (cdone) begin
                        err_spur_q <= 1'b1;
                    end
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    crd_q       <= 1'b0;
                    cwr_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cnt_q       <= {CW{1'b0}};
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_req_queue.sv
// Directed bench for ddr4_req_queue: read/write issue, ordering, full FIFO, backpressure,
// error flags and asynchronous reset mid-access.
module tb_ddr4_req_queue;

    localparam int AW  = 31;
    localparam int DW  = 4;
    localparam int TMO = 1024;

    logic          clkin = 1'b0;
    logic          crst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          crd, cwr;
    logic [AW-1:0] ca;
    logic [DW-1:0] cwdat, crdat;
    logic          cdone;
    logic [3:0]    level;
    logic          err_spur, err_tmo;

    int checks = 0;
    int errors = 0;

    ddr4_req_queue dut (
        .clkin(clkin), .crst(crst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .crd(crd), .cwr(cwr), .ca(ca), .cwdat(cwdat), .crdat(crdat), .cdone(cdone),
        .level(level), .err_spur(err_spur), .err_tmo(err_tmo)
    );

    always #5 clkin = ~clkin;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Wait for the next issue, complete it with cdone and do the response handshake.
    task automatic serve(input logic exp_we, input logic [AW-1:0] exp_addr,
                         input logic [DW-1:0] exp_wd, input logic [DW-1:0] rd);
        int n = 0;
        while (!(crd | cwr) && n < 50) begin
            tick();
            n++;
        end
        chk("issue", {63'd0, crd | cwr}, 64'd1);
        chk("cwr", {63'd0, cwr}, {63'd0, exp_we});
        chk("crd", {63'd0, crd}, {63'd0, ~exp_we});
        chk("ca", {33'd0, ca}, {33'd0, exp_addr});
        if (exp_we) chk("cwdat", {60'd0, cwdat}, {60'd0, exp_wd});
        cdone = 1'b1;
        crdat = rd;
        tick();
        cdone = 1'b0;
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_we", {63'd0, rsp_we}, {63'd0, exp_we});
        chk("rsp_rdata", {60'd0, rsp_rdata}, exp_we ? 64'd0 : {60'd0, rd});
        chk("drop_req", {62'd0, crd, cwr}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", {63'd0, rsp_valid}, 64'd0);
        chk("gap", {62'd0, crd, cwr}, 64'd0);
    endtask

    initial begin
        crst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; crdat = '0; cdone = 1'b0;
        #3;
        chk("rst_crd", {63'd0, crd}, 64'd0);
        chk("rst_level", {60'd0, level}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_ca", {33'd0, ca}, 64'd0);
        repeat (2) @(posedge clkin);
        #1 crst = 1'b0;
        chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

        // Single read
        req_valid = 1'b1; req_we = 1'b0; req_addr = 31'h0000_0400;
        tick();
        req_valid = 1'b0;
        chk("rd_level", {60'd0, level}, 64'd1);
        chk("rd_not_yet", {63'd0, crd}, 64'd0);
        tick();
        chk("rd_crd", {63'd0, crd}, 64'd1);
        chk("rd_ca", {33'd0, ca}, 64'h400);
        chk("rd_level0", {60'd0, level}, 64'd0);
        repeat (20) tick();
        chk("rd_hold", {63'd0, crd}, 64'd1);
        chk("rd_hold_ca", {33'd0, ca}, 64'h400);
        serve(1'b0, 31'h400, 4'h0, 4'hA);
        chk("rd_no_spur", {63'd0, err_spur}, 64'd0);

        // Back-to-back writes
        req_valid = 1'b1; req_we = 1'b1; req_addr = 31'h10; req_wdata = 4'd1;
        tick();
        req_addr = 31'h20; req_wdata = 4'd2;
        tick();
        chk("wr_first_issue", {63'd0, cwr}, 64'd1);
        chk("wr_level1", {60'd0, level}, 64'd1);
        req_addr = 31'h30; req_wdata = 4'd3;
        tick();
        req_valid = 1'b0;
        chk("wr_level2", {60'd0, level}, 64'd2);
        for (int k = 1; k <= 3; k++) begin
            serve(1'b1, 31'(k * 16), 4'(k), 4'hF);
        end
        chk("wr_drained", {60'd0, level}, 64'd0);

        // Full FIFO
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 31'(32'h100 + i); req_wdata = 4'(i);
            tick();
        end
        chk("full_level", {60'd0, level}, 64'd8);
        chk("full_ready", {63'd0, req_ready}, 64'd0);
        chk("full_head", {60'd0, cwdat}, 64'd0);
        req_addr = 31'h109; req_wdata = 4'd9;
        repeat (3) tick();
        chk("full_hold", {60'd0, level}, 64'd8);
        cdone = 1'b1; crdat = 4'h0;
        tick();
        cdone = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("full_hs_level", {60'd0, level}, 64'd8);
        tick();
        chk("full_pop_level", {60'd0, level}, 64'd7);
        chk("full_pop_ready", {63'd0, req_ready}, 64'd1);
        chk("full_pop_wd", {60'd0, cwdat}, 64'd1);
        tick();
        req_valid = 1'b0;
        chk("full_extra_in", {60'd0, level}, 64'd8);
        for (int k = 1; k <= 9; k++) begin
            serve(1'b1, 31'(32'h100 + k), 4'(k), 4'h0);
        end
        chk("full_drained", {60'd0, level}, 64'd0);

        // Response backpressure
        req_valid = 1'b1; req_we = 1'b0; req_addr = 31'h55;
        tick();
        req_we = 1'b1; req_addr = 31'h66; req_wdata = 4'd7;
        tick();
        req_valid = 1'b0;
        chk("bp_crd", {63'd0, crd}, 64'd1);
        cdone = 1'b1; crdat = 4'h6;
        tick();
        cdone = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rdata", {60'd0, rsp_rdata}, 64'h6);
            chk("bp_no_issue", {62'd0, crd, cwr}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_hs", {63'd0, rsp_valid}, 64'd0);
        chk("bp_gap", {63'd0, cwr}, 64'd0);
        tick();
        chk("bp_next", {63'd0, cwr}, 64'd1);
        serve(1'b1, 31'h66, 4'd7, 4'h0);

        // Errors
        cdone = 1'b1;
        tick();
        cdone = 1'b0;
        chk("spur", {63'd0, err_spur}, 64'd1);
        chk("spur_no_rsp", {63'd0, rsp_valid}, 64'd0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 31'h77;
        tick();
        req_valid = 1'b0;
        tick();
        chk("tmo_issue", {63'd0, crd}, 64'd1);
        repeat (TMO - 2) tick();
        chk("tmo_early", {63'd0, err_tmo}, 64'd0);
        repeat (4) tick();
        chk("tmo_set", {63'd0, err_tmo}, 64'd1);
        chk("tmo_crd_held", {63'd0, crd}, 64'd1);
        serve(1'b0, 31'h77, 4'h0, 4'h3);
        chk("tmo_sticky", {62'd0, err_spur, err_tmo}, 64'd3);

        // Reset mid-access
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 31'(i);
            tick();
        end
        req_valid = 1'b0;
        chk("mid_crd", {63'd0, crd}, 64'd1);
        chk("mid_level", {60'd0, level}, 64'd3);
        #2 crst = 1'b1;
        #1;
        chk("async_crd", {63'd0, crd}, 64'd0);
        chk("async_level", {60'd0, level}, 64'd0);
        chk("async_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("async_errs", {62'd0, err_spur, err_tmo}, 64'd0);
        tick();
        crst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_stale", {62'd0, crd, cwr}, 64'd0);
            chk("no_stale_lvl", {60'd0, level}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
